// File: rtl/bf_out_queue_if.sv
// Byte handshake between the BF machine (master) and the output queue (slave).
interface bf_out_queue_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/bf_out_queue.sv
// Output byte FIFO with hex-display head view and key-driven pop.
// Optional key debouncer enabled by defining BF_OUTQ_DEBOUNCE_EN.
module bf_out_queue #(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                     clock,
    input  logic                     resetn,
    bf_out_queue_if.slave            out,
    input  logic                     step_key,
    input  logic                     flush,
    output logic [7:0]               disp_data,
    output logic                     disp_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          sync1_q, sync2_q;
    logic          level, level_prev_q;
    logic          pop_pulse, empty, push, pop;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= step_key;
            sync2_q <= sync1_q;
        end
    end

`ifdef BF_OUTQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_q, deb_d;

    // Level follows the synchronizer only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_comb begin
        deb_cnt_d = '0;
        deb_d     = deb_q;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            deb_cnt_q <= '0;
            deb_q     <= 1'b1;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            deb_q     <= deb_d;
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) level_prev_q <= 1'b1;
        else         level_prev_q <= level;
    end

    assign pop_pulse = level_prev_q & ~level;

    assign empty         = (count_q == '0);
    assign full          = (count_q == CW'(DEPTH));
    assign out.out_ready = ~full;
    assign push          = out.out_valid & ~full;
    assign pop           = pop_pulse & ~empty;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_q] <= out.out_data;
    end

    assign count      = count_q;
    assign disp_valid = ~empty;
    assign disp_data  = empty ? 8'h00 : mem_q[rd_q];
endmodule

// File: tb/tb_bf_out_queue.sv
// Directed self-checking bench for bf_out_queue (DEPTH=8; debounce steps when BF_OUTQ_DEBOUNCE_EN).
module tb_bf_out_queue;
    logic       clock = 1'b0;
    logic       resetn;
    logic       step_key;
    logic       flush;
    logic [7:0] disp_data;
    logic       disp_valid;
    logic [3:0] count;
    logic       full;
    int         checks = 0;
    int         failures = 0;

    bf_out_queue_if bus ();

    bf_out_queue #(.DEPTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .out        (bus.slave),
        .step_key   (step_key),
        .flush      (flush),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .count      (count),
        .full       (full)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.out_data  = b;
        bus.out_valid = 1'b1;
        tick();
        bus.out_valid = 1'b0;
    endtask

    task automatic press();
        step_key = 1'b0;
        repeat (3) tick();
        step_key = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        resetn        = 1'b0;
        step_key      = 1'b1;
        flush         = 1'b0;
        bus.out_data  = 8'h00;
        bus.out_valid = 1'b0;
        repeat (2) tick();
        chk("rst_ready", int'(bus.out_ready), 1);
        chk("rst_dvalid", int'(disp_valid), 0);
        chk("rst_ddata", int'(disp_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        resetn = 1'b1;
        repeat (3) tick();
        chk("rst_nopop", int'(count), 0);

        push(8'h48);
        chk("push1_latency", int'(disp_data), 8'h48);
        chk("push1_dvalid", int'(disp_valid), 1);
        push(8'h69);
        chk("push2_head", int'(disp_data), 8'h48);
        chk("push2_count", int'(count), 2);

        step_key = 1'b0;
        repeat (2) tick();
        chk("key_edge2_head", int'(disp_data), 8'h48);
        tick();
        chk("key_edge3_head", int'(disp_data), 8'h69);
        chk("key_edge3_count", int'(count), 1);
        step_key = 1'b1;
        repeat (3) tick();
        chk("release_nopop", int'(count), 1);
        press();
        chk("pop_empty_dvalid", int'(disp_valid), 0);
        chk("pop_empty_ddata", int'(disp_data), 0);

        for (int i = 1; i <= 8; i++) push(8'(i));
        chk("full_flag", int'(full), 1);
        chk("full_ready", int'(bus.out_ready), 0);
        chk("full_count", int'(count), 8);
        bus.out_data  = 8'h09;
        bus.out_valid = 1'b1;
        repeat (2) tick();
        chk("full_blocked_count", int'(count), 8);
        chk("full_blocked_head", int'(disp_data), 8'h01);
        step_key = 1'b0;
        repeat (3) tick();
        chk("full_pop_full", int'(full), 0);
        chk("full_pop_count", int'(count), 7);
        tick();
        bus.out_valid = 1'b0;
        chk("refill_count", int'(count), 8);
        chk("refill_full", int'(full), 1);
        step_key = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wrap_head%0d", i), int'(disp_data), 2 + i);
            press();
        end
        chk("wrap_empty", int'(count), 0);

        push(8'h10);
        push(8'h20);
        push(8'h30);
        step_key = 1'b0;
        repeat (2) tick();
        bus.out_data  = 8'h7A;
        bus.out_valid = 1'b1;
        tick();
        bus.out_valid = 1'b0;
        chk("simul_count", int'(count), 3);
        chk("simul_head", int'(disp_data), 8'h20);
        step_key = 1'b1;
        repeat (3) tick();
        press();
        chk("simul_next", int'(disp_data), 8'h30);
        press();
        chk("simul_last", int'(disp_data), 8'h7A);
        press();
        chk("simul_drained", int'(count), 0);

        press();
        push(8'h33);
        chk("empty_press_discarded", int'(disp_data), 8'h33);
        chk("empty_press_count", int'(count), 1);
        push(8'h34);
        push(8'h35);
        push(8'h36);
        push(8'h37);
        chk("preflush_count", int'(count), 5);
        flush         = 1'b1;
        bus.out_data  = 8'h55;
        bus.out_valid = 1'b1;
        tick();
        flush         = 1'b0;
        bus.out_valid = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_dvalid", int'(disp_valid), 0);
        chk("flush_ready", int'(bus.out_ready), 1);
        push(8'h66);
        chk("postflush_head", int'(disp_data), 8'h66);
        chk("postflush_count", int'(count), 1);

        push(8'h11);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_count", int'(count), 0);
        chk("async_reset_dvalid", int'(disp_valid), 0);
        tick();
        resetn = 1'b1;
        repeat (2) tick();

`ifdef BF_OUTQ_DEBOUNCE_EN
        push(8'hA1);
        push(8'hA2);
        for (int r = 0; r < 5; r++) begin
            step_key = 1'b0;
            repeat (3) tick();
            step_key = 1'b1;
            repeat (3) tick();
        end
        chk("bounce_nopop", int'(count), 2);
        step_key = 1'b0;
        repeat (6) tick();
        chk("deb_edge6_head", int'(disp_data), 8'hA1);
        tick();
        chk("deb_edge7_head", int'(disp_data), 8'hA2);
        repeat (3) tick();
        step_key = 1'b1;
        repeat (10) tick();
        chk("deb_single_pop", int'(count), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bf_out_queue.md
# bf_out_queue

Output-side receiver for the BF machine's byte output interface. It accepts each byte the machine emits through a valid/ready handshake, holds it in a small FIFO, and shows the oldest unread byte to the board's hex displays. A board key steps the display to the next byte. While the queue is full the machine stalls.

## Interface

Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `DEBOUNCE_CYCLES`, 250000: number of stable cycles required by the debouncer. Used only when `BF_OUTQ_DEBOUNCE_EN` is defined.

Ports:
- `clock`  in  1  System clock. Every flop in the block is rising-edge on this clock.
- `resetn`  in  1  Reset, asynchronous assert, active-low.
- `out_data`  in  8  Byte from the machine.
- `out_valid`  in  1  The machine is presenting `out_data`.
- `out_ready`  out  1  The queue can accept a byte. Equal to `~full`.
- `step_key`  in  1  Raw board key, active-low, asynchronous to `clock`.
- `flush`  in  1  Synchronous clear of the queue contents.
- `disp_data`  out  8  Head byte when the queue is non-empty; 0x00 when empty.
- `disp_valid`  out  1  The queue is non-empty.
- `count`  out  $clog2(DEPTH)+1  Number of stored bytes, range 0..DEPTH.
- `full`  out  1  `count == DEPTH`.

## Operation

- **Storage:** `DEPTH`×8 register array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo `DEPTH`. `count` is kept as a separate register.
- **Push:** happens on a rising edge where `out_valid & out_ready` is true. `out_data` is written at the write pointer, the write pointer increments, and `count` increments.
  - The machine must hold `out_data` and `out_valid` until it sees `out_ready` high.
  - When `out_ready` is low, `out_valid` is ignored and nothing is stored.
- **Key path:**
  - `step_key` passes through a 2-flop synchronizer.
  - The synchronized level feeds the debouncer (see Configuration).
  - A one-cycle `pop_pulse` is generated on the press edge (1→0) of the resulting level.
  - Releasing the key produces no pulse.
- **Pop:** happens when `pop_pulse & ~empty`. The read pointer increments and `count` decrements. A `pop_pulse` while the queue is empty is discarded; it is not remembered.
- **Simultaneous push and pop:** both take effect in the same cycle.
  - Neither pointer is disturbed by the other operation.
  - `count` is unchanged.
- **Full:** `out_ready` is 0, so no push is possible. A pop on the full cycle lowers `full` on the next edge. A push can be accepted from that cycle on.
- **Empty:** if a push and a pop coincide on an empty queue, only the push takes effect.
- **Flush:** `flush` high on an edge resets both pointers to 0 and `count` to 0.
  - Flush overrides any push or pop in the same cycle.
  - The byte offered in that cycle is not accepted.
  - Array contents are not cleared.
- **Display:** `disp_data` reads the array at the read pointer, gated to 0x00 when `count == 0`. It is combinational from registers, with no path from inputs.

## Timing

- **Reset values:** pointers 0; `count` 0; `full` 0; `out_ready` 1; `disp_valid` 0; `disp_data` 0x00.
  - Synchronizer and debounce state reset to the released level (1), so no pulse is generated when reset is released.
- **Push latency:** a byte pushed into an empty queue appears on `disp_data`, with `disp_valid` = 1, after the same rising edge that accepts it.
- **Key latency without debounce:** the first edge that samples `step_key` low is edge 1. `pop_pulse` is high during the cycle after edge 2. The display advances at edge 3.
- **Key latency with debounce:** the debounced level falls after `DEBOUNCE_CYCLES` consecutive synchronized-low samples. The display advances one edge later.
- **Reset mid-transfer:** asserting `resetn` low clears the queue immediately (asynchronously). Any byte whose handshake had not completed on a rising edge is lost.

## Configuration

- **`BF_OUTQ_DEBOUNCE_EN` defined:**
  - A counter of width $clog2(DEBOUNCE_CYCLES+1) runs while the synchronized key differs from the debounced level.
  - The counter resets to 0 whenever the two agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value.
  - Bounces shorter than `DEBOUNCE_CYCLES` produce no pulse.
- **`BF_OUTQ_DEBOUNCE_EN` undefined:**
  - The debounced level is the synchronizer output directly.
  - No counter is instantiated and `DEBOUNCE_CYCLES` is unused.
  - Each synchronized 1→0 transition pops one byte.

## Test plan

All cases use `DEPTH`=8 and the macro undefined, unless stated otherwise.

- **Reset:** hold `resetn` low → `out_ready`=1, `disp_valid`=0, `disp_data`=0x00, `count`=0.
- **Basic push/pop:** push 0x48, then 0x69 → `disp_data`=0x48, `count`=2. Press the key once → 3 edges later `disp_data`=0x69, `count`=1. Press again → `disp_valid`=0, `disp_data`=0x00.
- **Full and wrap-around:**
  - Push 0x01..0x08 → `full`=1, `out_ready`=0.
  - Hold 0x09 valid → it is not accepted.
  - Press the key → `full`=0 the next edge, and 0x09 is accepted on the following edge.
  - Pop all entries → the sequence 0x02..0x09 is displayed in order across the pointer wrap.
- **Simultaneous push/pop:** at `count`=3, drive a push of 0x7A in the cycle where `pop_pulse` is high → `count` stays 3, the head advances by one entry, and 0x7A is the last entry.
- **Empty pop and flush:**
  - Press the key while empty, then push 0x33 → `disp_data`=0x33, so the empty press was discarded.
  - Flush at `count`=5 while `out_valid` is high → `count`=0 and the offered byte is dropped.
- **Debounce (`BF_OUTQ_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4):**
  - Key low for 3 cycles, then high, repeated 5 times → no pop.
  - Key low for 10 cycles → exactly one pop, and the display advances 2 sync edges + 4 stable cycles + 1 edge after the press.
